// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM stage: load/store func3 codes, write-back selects,
// the access FSM state type, and helpers for alignment checks and lane selection.
package rv_mem_pkg;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;
  localparam logic [2:0] FUNC3_SW  = 3'b010;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } mem_state_e;

  // Misaligned halfword/word, or a func3 that encodes no legal access size.
  function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      FUNC3_LH, FUNC3_LHU:       return a[0];
      FUNC3_LW:                  return a != 2'b00;
      3'b011, 3'b110, 3'b111:    return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Low address bits masked to the natural alignment of the access size.
  function automatic logic [1:0] size_align(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: replicates store data across byte lanes with matching
// byte enables, and extracts/extends the addressed byte or half of a loaded word.
module load_store_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [31:0] write_data_o,
  output logic [3:0]  byte_en_o,
  output logic [31:0] load_value_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    write_data_o = store_data_i;
    byte_en_o    = 4'b1111;
    load_value_o = load_word_i;
    sel_byte     = load_word_i[{lane_i, 3'b000} +: 8];
    sel_half     = load_word_i[{lane_i[1], 4'b0000} +: 16];
    case (func3_i[1:0])
      2'b00: begin
        write_data_o = {4{store_data_i[7:0]}};
        byte_en_o    = 4'b0001 << lane_i;
        load_value_o = func3_i[2] ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      2'b01: begin
        write_data_o = {2{store_data_i[15:0]}};
        byte_en_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        load_value_o = func3_i[2] ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: sequences one data-memory access per load/store over a busywait
// handshake, stalls the pipeline meanwhile, and owns the MEM/WB register.
module mem_stage_ctrl
  import rv_mem_pkg::*;
#(
  parameter bit FAULT_ON_MISALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REG_WRITE_EN_EXMEM,
  input  logic [1:0]  WB_VALUE_SEL_EXMEM,
  input  logic        MEM_READ_EN_EXMEM,
  input  logic        MEM_WRITE_EN_EXMEM,
  input  logic [31:0] PC_EXMEM,
  input  logic [31:0] RESULT_EXMEM,
  input  logic [31:0] REG_DATA_2_EXMEM,
  input  logic [2:0]  FUNC3_EXMEM,
  input  logic [4:0]  REG_WRITE_ADDR_EXMEM,
  input  logic        DMEM_BUSYWAIT,
  input  logic [31:0] DMEM_READDATA,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WRITEDATA,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic        MEM_BUSYWAIT,
  output logic        REG_WRITE_EN_MEMWB,
  output logic [1:0]  WB_VALUE_SEL_MEMWB,
  output logic [31:0] PC_MEMWB,
  output logic [31:0] RESULT_MEMWB,
  output logic [31:0] LOAD_DATA_MEMWB,
  output logic [4:0]  REG_WRITE_ADDR_MEMWB,
  output logic        MEM_FAULT_MEMWB
);

  mem_state_e  state_q;
  logic        dmem_read_q, dmem_write_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q, load_q;
  logic [3:0]  dmem_be_q;
  logic        wb_we_q, wb_fault_q;
  logic [1:0]  wb_sel_q;
  logic [31:0] wb_pc_q, wb_result_q, wb_load_q;
  logic [4:0]  wb_rd_q;

  logic        acc, is_read, fault, stall;
  logic [1:0]  lane;
  logic [31:0] al_wdata, al_load;
  logic [3:0]  al_be;

  // A simultaneous read+write request is treated as a store only.
  assign acc     = MEM_READ_EN_EXMEM | MEM_WRITE_EN_EXMEM;
  assign is_read = MEM_READ_EN_EXMEM & ~MEM_WRITE_EN_EXMEM;
  assign fault   = acc & FAULT_ON_MISALIGN & access_fault(FUNC3_EXMEM, RESULT_EXMEM[1:0]);
  assign lane    = size_align(FUNC3_EXMEM, RESULT_EXMEM[1:0]);
  assign stall   = ((state_q == S_IDLE) & acc & ~fault) | (state_q == S_ACCESS);

  load_store_align u_align (
    .func3_i      (FUNC3_EXMEM),
    .lane_i       (lane),
    .store_data_i (REG_DATA_2_EXMEM),
    .load_word_i  (DMEM_READDATA),
    .write_data_o (al_wdata),
    .byte_en_o    (al_be),
    .load_value_o (al_load)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_be_q    <= '0;
      load_q       <= '0;
      wb_we_q      <= 1'b0;
      wb_fault_q   <= 1'b0;
      wb_sel_q     <= '0;
      wb_pc_q      <= '0;
      wb_result_q  <= '0;
      wb_load_q    <= '0;
      wb_rd_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (acc && !fault) begin
            dmem_read_q  <= is_read;
            dmem_write_q <= MEM_WRITE_EN_EXMEM;
            dmem_addr_q  <= {RESULT_EXMEM[31:2], 2'b00};
            dmem_wdata_q <= al_wdata;
            dmem_be_q    <= al_be;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!DMEM_BUSYWAIT) begin
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            load_q       <= is_read ? al_load : 32'h0;
            state_q      <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // EX/MEM is held while stalled, so its fields are still this instruction's in DONE.
      if (!stall) begin
        wb_we_q     <= REG_WRITE_EN_EXMEM & ~fault;
        wb_fault_q  <= fault;
        wb_sel_q    <= WB_VALUE_SEL_EXMEM;
        wb_pc_q     <= PC_EXMEM;
        wb_result_q <= RESULT_EXMEM;
        wb_rd_q     <= REG_WRITE_ADDR_EXMEM;
        wb_load_q   <= (state_q == S_DONE) ? load_q : 32'h0;
      end
    end
  end

  assign MEM_BUSYWAIT         = stall;
  assign DMEM_READ            = dmem_read_q;
  assign DMEM_WRITE           = dmem_write_q;
  assign DMEM_ADDR            = dmem_addr_q;
  assign DMEM_WRITEDATA       = dmem_wdata_q;
  assign DMEM_BYTE_EN         = dmem_be_q;
  assign REG_WRITE_EN_MEMWB   = wb_we_q;
  assign WB_VALUE_SEL_MEMWB   = wb_sel_q;
  assign PC_MEMWB             = wb_pc_q;
  assign RESULT_MEMWB         = wb_result_q;
  assign LOAD_DATA_MEMWB      = wb_load_q;
  assign REG_WRITE_ADDR_MEMWB = wb_rd_q;
  assign MEM_FAULT_MEMWB      = wb_fault_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Table-driven bench for mem_stage_ctrl with a small byte-enabled memory model
// whose busywait length is set per instruction, plus a mid-access reset sequence.
module tb_mem_stage_ctrl;
  import rv_mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REG_WRITE_EN_EXMEM, MEM_READ_EN_EXMEM, MEM_WRITE_EN_EXMEM;
  logic [1:0]  WB_VALUE_SEL_EXMEM;
  logic [31:0] PC_EXMEM, RESULT_EXMEM, REG_DATA_2_EXMEM;
  logic [2:0]  FUNC3_EXMEM;
  logic [4:0]  REG_WRITE_ADDR_EXMEM;
  logic        DMEM_BUSYWAIT;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_READ, DMEM_WRITE, MEM_BUSYWAIT;
  logic [31:0] DMEM_ADDR, DMEM_WRITEDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic        REG_WRITE_EN_MEMWB, MEM_FAULT_MEMWB;
  logic [1:0]  WB_VALUE_SEL_MEMWB;
  logic [31:0] PC_MEMWB, RESULT_MEMWB, LOAD_DATA_MEMWB;
  logic [4:0]  REG_WRITE_ADDR_MEMWB;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.FAULT_ON_MISALIGN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .REG_WRITE_EN_EXMEM(REG_WRITE_EN_EXMEM), .WB_VALUE_SEL_EXMEM(WB_VALUE_SEL_EXMEM),
    .MEM_READ_EN_EXMEM(MEM_READ_EN_EXMEM), .MEM_WRITE_EN_EXMEM(MEM_WRITE_EN_EXMEM),
    .PC_EXMEM(PC_EXMEM), .RESULT_EXMEM(RESULT_EXMEM), .REG_DATA_2_EXMEM(REG_DATA_2_EXMEM),
    .FUNC3_EXMEM(FUNC3_EXMEM), .REG_WRITE_ADDR_EXMEM(REG_WRITE_ADDR_EXMEM),
    .DMEM_BUSYWAIT(DMEM_BUSYWAIT), .DMEM_READDATA(DMEM_READDATA),
    .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WRITEDATA(DMEM_WRITEDATA), .DMEM_BYTE_EN(DMEM_BYTE_EN), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .REG_WRITE_EN_MEMWB(REG_WRITE_EN_MEMWB), .WB_VALUE_SEL_MEMWB(WB_VALUE_SEL_MEMWB),
    .PC_MEMWB(PC_MEMWB), .RESULT_MEMWB(RESULT_MEMWB), .LOAD_DATA_MEMWB(LOAD_DATA_MEMWB),
    .REG_WRITE_ADDR_MEMWB(REG_WRITE_ADDR_MEMWB), .MEM_FAULT_MEMWB(MEM_FAULT_MEMWB)
  );

  // Memory model: busy for busy_cycles cycles after a strobe appears, then completes.
  logic [31:0] mem [0:255];
  int          busy_cycles = 0;
  int          cnt = 0;
  logic        mem_clear = 1'b0, poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign DMEM_BUSYWAIT = (DMEM_READ || DMEM_WRITE) && (cnt < busy_cycles);
  assign DMEM_READDATA = mem[DMEM_ADDR[9:2]];

  always @(posedge CLK) begin
    cnt <= (DMEM_READ || DMEM_WRITE) ? cnt + 1 : 0;
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (DMEM_WRITE && !DMEM_BUSYWAIT) begin
      for (int b = 0; b < 4; b++)
        if (DMEM_BYTE_EN[b]) mem[DMEM_ADDR[9:2]][8*b +: 8] <= DMEM_WRITEDATA[8*b +: 8];
    end
  end

  typedef struct {
    logic        rd, wr, we;
    logic [1:0]  wbsel;
    logic [2:0]  f3;
    logic [31:0] addr, data, pc;
    logic [4:0]  rdi;
    int          nbusy;
    int          e_busy, e_rd, e_wr;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we, e_fault;
    logic [31:0] e_load;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          checks = 0;
  logic [31:0] prev_result = '0;
  vec_t        tbl [18];

  function automatic vec_t mkv(input logic rd, wr, we, input logic [1:0] wbsel,
                               input logic [2:0] f3, input logic [31:0] addr, data, pc,
                               input logic [4:0] rdi, input int nbusy, e_busy, e_rd, e_wr,
                               input logic [31:0] e_addr, e_wdata, input logic [3:0] e_be,
                               input logic e_we, e_fault, input logic [31:0] e_load);
    vec_t v;
    v.rd = rd; v.wr = wr; v.we = we; v.wbsel = wbsel; v.f3 = f3;
    v.addr = addr; v.data = data; v.pc = pc; v.rdi = rdi; v.nbusy = nbusy;
    v.e_busy = e_busy; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_be = e_be; v.e_we = e_we; v.e_fault = e_fault; v.e_load = e_load;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    REG_WRITE_EN_EXMEM = 0; WB_VALUE_SEL_EXMEM = 0; MEM_READ_EN_EXMEM = 0;
    MEM_WRITE_EN_EXMEM = 0; PC_EXMEM = 0; RESULT_EXMEM = 0; REG_DATA_2_EXMEM = 0;
    FUNC3_EXMEM = 0; REG_WRITE_ADDR_EXMEM = 0;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the edge
  // at which MEM/WB captured this instruction.
  task automatic run_instr(input int id, input vec_t v);
    int          busy_n = 0, rd_n = 0, wr_n = 0;
    logic        done = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [3:0]  s_be = '0;
    busy_cycles          = v.nbusy;
    REG_WRITE_EN_EXMEM   = v.we;    WB_VALUE_SEL_EXMEM = v.wbsel;
    MEM_READ_EN_EXMEM    = v.rd;    MEM_WRITE_EN_EXMEM = v.wr;
    PC_EXMEM             = v.pc;    RESULT_EXMEM       = v.addr;
    REG_DATA_2_EXMEM     = v.data;  FUNC3_EXMEM        = v.f3;
    REG_WRITE_ADDR_EXMEM = v.rdi;
    for (int c = 0; c < 40 && !done; c++) begin
      #3;
      if (DMEM_READ)  begin rd_n++; s_addr = DMEM_ADDR; s_be = DMEM_BYTE_EN; end
      if (DMEM_WRITE) begin wr_n++; s_addr = DMEM_ADDR; s_be = DMEM_BYTE_EN; s_wdata = DMEM_WRITEDATA; end
      if (MEM_BUSYWAIT) begin
        busy_n++;
        chk("memwb_hold", RESULT_MEMWB, prev_result);
      end else begin
        done = 1'b1;
      end
      @(posedge CLK); #1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL vec%0d timeout: MEM_BUSYWAIT still 1 after 40 cycles, required 0", id);
    end
    chk("busy_cycles", busy_n, v.e_busy);
    chk("read_cycles", rd_n, v.e_rd);
    chk("write_cycles", wr_n, v.e_wr);
    if (v.e_rd + v.e_wr > 0) begin
      chk("dmem_addr", s_addr, v.e_addr);
      chk("dmem_be", {28'b0, s_be}, {28'b0, v.e_be});
    end
    if (v.e_wr > 0) chk("dmem_wdata", s_wdata, v.e_wdata);
    chk("we_memwb", REG_WRITE_EN_MEMWB, v.e_we);
    chk("fault_memwb", MEM_FAULT_MEMWB, v.e_fault);
    chk("load_memwb", LOAD_DATA_MEMWB, v.e_load);
    chk("result_memwb", RESULT_MEMWB, v.addr);
    chk("pc_memwb", PC_MEMWB, v.pc);
    chk("rd_memwb", REG_WRITE_ADDR_MEMWB, v.rdi);
    chk("wbsel_memwb", WB_VALUE_SEL_MEMWB, v.wbsel);
    prev_result = v.addr;
    vectors++;
    $display("vec %0d: addr=%h busy=%0d rd=%0d wr=%0d load=%h fault=%0b miscompares=%0d",
             id, v.addr, busy_n, rd_n, wr_n, LOAD_DATA_MEMWB, MEM_FAULT_MEMWB, miscompares);
  endtask

  initial begin
    //            rd wr we wbsel       f3         addr          data          pc          rd  N  bsy rd wr e_addr      e_wdata       be     we flt load
    tbl[0]  = mkv(0, 0, 1, WB_SEL_ALU, 3'b000,    32'h1234,     32'h0,        32'h1000,   5,  0, 0,  0, 0, 32'h0,      32'h0,        4'h0,  1, 0, 32'h0);
    tbl[1]  = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LW,  32'h100,      32'h0,        32'h1004,   6,  3, 5,  4, 0, 32'h100,    32'h0,        4'hF,  1, 0, 32'hDEADBEEF);
    tbl[2]  = mkv(0, 1, 0, WB_SEL_ALU, FUNC3_SB,  32'h203,      32'hA5,       32'h1008,   0,  0, 2,  0, 1, 32'h200,    32'hA5A5A5A5, 4'h8,  0, 0, 32'h0);
    tbl[3]  = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LB,  32'h203,      32'h0,        32'h100C,   7,  1, 3,  2, 0, 32'h200,    32'h0,        4'h8,  1, 0, 32'hFFFFFFA5);
    tbl[4]  = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LBU, 32'h203,      32'h0,        32'h1010,   8,  0, 2,  1, 0, 32'h200,    32'h0,        4'h8,  1, 0, 32'h000000A5);
    tbl[5]  = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LH,  32'h101,      32'h0,        32'h1014,   9,  0, 0,  0, 0, 32'h0,      32'h0,        4'h0,  0, 1, 32'h0);
    tbl[6]  = mkv(0, 1, 0, WB_SEL_ALU, FUNC3_SW,  32'h10,       32'h12345678, 32'h1018,   0,  2, 4,  0, 3, 32'h10,     32'h12345678, 4'hF,  0, 0, 32'h0);
    tbl[7]  = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LW,  32'h10,       32'h0,        32'h101C,   10, 0, 2,  1, 0, 32'h10,     32'h0,        4'hF,  1, 0, 32'h12345678);
    tbl[8]  = mkv(0, 1, 0, WB_SEL_ALU, FUNC3_SH,  32'h202,      32'h0000BEEF, 32'h1020,   0,  1, 3,  0, 2, 32'h200,    32'hBEEFBEEF, 4'hC,  0, 0, 32'h0);
    tbl[9]  = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LH,  32'h202,      32'h0,        32'h1024,   11, 0, 2,  1, 0, 32'h200,    32'h0,        4'hC,  1, 0, 32'hFFFFBEEF);
    tbl[10] = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LHU, 32'h202,      32'h0,        32'h1028,   12, 0, 2,  1, 0, 32'h200,    32'h0,        4'hC,  1, 0, 32'h0000BEEF);
    tbl[11] = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LW,  32'h102,      32'h0,        32'h102C,   13, 0, 0,  0, 0, 32'h0,      32'h0,        4'h0,  0, 1, 32'h0);
    tbl[12] = mkv(1, 0, 1, WB_SEL_MEM, 3'b011,    32'h0,        32'h0,        32'h1030,   14, 0, 0,  0, 0, 32'h0,      32'h0,        4'h0,  0, 1, 32'h0);
    tbl[13] = mkv(1, 1, 1, WB_SEL_ALU, FUNC3_SW,  32'h20,       32'hCAFEF00D, 32'h1034,   15, 0, 2,  0, 1, 32'h20,     32'hCAFEF00D, 4'hF,  1, 0, 32'h0);
    tbl[14] = mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LW,  32'h20,       32'h0,        32'h1038,   16, 0, 2,  1, 0, 32'h20,     32'h0,        4'hF,  1, 0, 32'hCAFEF00D);
    tbl[15] = mkv(0, 0, 0, WB_SEL_PC4, 3'b000,    32'h55,       32'h0,        32'h103C,   17, 0, 0,  0, 0, 32'h0,      32'h0,        4'h0,  0, 0, 32'h0);
    tbl[16] = mkv(0, 1, 0, WB_SEL_ALU, FUNC3_SH,  32'h11,       32'h1,        32'h1040,   0,  0, 0,  0, 0, 32'h0,      32'h0,        4'h0,  0, 1, 32'h0);
    tbl[17] = mkv(0, 0, 1, WB_SEL_ALU, 3'b000,    32'hFFFFFFFF, 32'h0,        32'h1044,   31, 0, 0,  0, 0, 32'h0,      32'h0,        4'h0,  1, 0, 32'h0);

    RESET = 1'b1;
    drive_idle();
    mem_clear = 1'b1;
    @(posedge CLK); #1;
    mem_clear = 1'b0;
    poke_en = 1'b1; poke_idx = 8'h40; poke_val = 32'hDEADBEEF;
    chk("rst_dmem_read", DMEM_READ, 0);
    chk("rst_dmem_write", DMEM_WRITE, 0);
    chk("rst_dmem_addr", DMEM_ADDR, 0);
    chk("rst_busywait", MEM_BUSYWAIT, 0);
    chk("rst_we_memwb", REG_WRITE_EN_MEMWB, 0);
    chk("rst_load_memwb", LOAD_DATA_MEMWB, 0);
    chk("rst_fault_memwb", MEM_FAULT_MEMWB, 0);
    vectors++;
    @(posedge CLK); #1;
    poke_en = 1'b0;
    RESET = 1'b0;

    for (int i = 0; i < 18; i++) run_instr(i, tbl[i]);

    // Reset in the middle of a stalled load aborts it immediately.
    busy_cycles = 5;
    REG_WRITE_EN_EXMEM = 1; WB_VALUE_SEL_EXMEM = WB_SEL_MEM; MEM_READ_EN_EXMEM = 1;
    MEM_WRITE_EN_EXMEM = 0; PC_EXMEM = 32'h2000; RESULT_EXMEM = 32'h100;
    FUNC3_EXMEM = FUNC3_LW; REG_WRITE_ADDR_EXMEM = 3;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("prereset_read", DMEM_READ, 1);
    chk("prereset_pc_memwb", PC_MEMWB, 32'h1044);
    #2 RESET = 1'b1;
    #1;
    chk("midrst_dmem_read", DMEM_READ, 0);
    chk("midrst_dmem_write", DMEM_WRITE, 0);
    chk("midrst_dmem_addr", DMEM_ADDR, 0);
    chk("midrst_we_memwb", REG_WRITE_EN_MEMWB, 0);
    chk("midrst_pc_memwb", PC_MEMWB, 0);
    chk("midrst_result_memwb", RESULT_MEMWB, 0);
    chk("midrst_rd_memwb", REG_WRITE_ADDR_MEMWB, 0);
    chk("midrst_wbsel_memwb", WB_VALUE_SEL_MEMWB, 0);
    vectors++;
    $display("reset-mid-access: read=%0b pc_memwb=%h miscompares=%0d", DMEM_READ, PC_MEMWB, miscompares);
    @(posedge CLK); #1;
    drive_idle();
    RESET = 1'b0;
    prev_result = '0;
    run_instr(100, mkv(1, 0, 1, WB_SEL_MEM, FUNC3_LW, 32'h100, 32'h0, 32'h2004, 4, 0,
                       2, 1, 0, 32'h100, 32'h0, 4'hF, 1, 0, 32'hDEADBEEF));
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
